// File: rtl/boot_loader.sv
// boot_loader: byte-stream program loader in front of the multicycle RISC-V core.
// Receives a frame  MAGIC, CNT[7:0], CNT[15:8], CNT little-endian words [, checksum]
// over a valid/ready byte stream. It writes each assembled word into the core
// memory through a single-cycle write port. The core is held in reset until a
// complete, valid image has been written.
//
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   rx_valid_i   byte available
//   rx_data_i    byte value
//   rx_ready_o   loader accepts a byte this cycle
//   mem_we_o     memory write strobe, one cycle per word
//   mem_addr_o   word address (ADDR_W bits)
//   mem_wdata_o  word data
//   core_rstn_o  core reset, active-low
//   busy_o       frame in progress
//   err_o        last frame rejected
module boot_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rstn_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen0  = 3'd1;
  localparam logic [2:0] StLen1  = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StChk   = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StError = 3'd7;

`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] StAfterLast = StChk;
`else
  localparam logic [2:0] StAfterLast = StDone;
`endif

  // Largest legal word count: the full memory.
  localparam logic [16:0]       MaxCnt   = 17'(64'd1 << ADDR_W);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;      // lower three bytes; the 4th goes straight out
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rstn_q;

  logic              rdy_st;
  logic              xfer;
  logic [15:0]       cnt_full;

  // Ready is decoded from state only; forced low while reset is held.
  assign rdy_st     = (state_q != StWrite) && (state_q != StDone);
  assign rx_ready_o = rdy_st & ~rst_i;
  assign xfer       = rx_valid_i & rdy_st;
  assign cnt_full   = {rx_data_i, cnt_q[7:0]};

  assign mem_we_o    = (state_q == StWrite);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign core_rstn_o = core_rstn_q;
  assign busy_o      = (state_q == StLen0) || (state_q == StLen1) || (state_q == StData) ||
                       (state_q == StWrite) || (state_q == StChk);
  assign err_o       = (state_q == StError);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    chk_d      = chk_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      StIdle, StError: begin
        if (xfer && rx_data_i == MAGIC) begin
          state_d    = StLen0;
          chk_d      = 8'h00;
          byte_idx_d = 2'd0;
          word_idx_d = 16'd0;
        end
      end
      StLen0: begin
        if (xfer) begin
          cnt_d[7:0] = rx_data_i;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (xfer) begin
          cnt_d = cnt_full;
          if ({1'b0, cnt_full} > MaxCnt) begin
            state_d = StError;
          end else if (cnt_full == 16'd0) begin
            state_d = StAfterLast;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          chk_d      = chk_q ^ rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            addr_d  = BaseAddr + word_idx_q[ADDR_W-1:0];
            wdata_d = {rx_data_i, word_q};
            state_d = StWrite;
          end else begin
            word_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_d == cnt_q) ? StAfterLast : StData;
      end
`ifdef BOOT_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          state_d = (rx_data_i == chk_q) ? StDone : StError;
        end
      end
`endif
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      // Sticky once the image is complete; only rst_i clears it.
      core_rstn_q <= core_rstn_q | (state_q == StDone);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a scoreboard of expected memory writes is
// filled as payload bytes are driven and drained by a monitor on every mem_we_o.
module tb_boot_loader;

  localparam int unsigned ADDR_W = 10;
  localparam logic [7:0]  MAGIC  = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              rx_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_rstn_o;
  logic              busy_o;
  logic              err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [31:0]       pay[16];

  boot_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .MAGIC     (MAGIC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .core_rstn_o (core_rstn_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: drain scoreboard on writes; ready must be low exactly in write cycles.
  always @(negedge clk) begin
    if (!rst_i && busy_o) check_eq("ready_vs_write", rx_ready_o, !mem_we_o);
    if (!rst_i && mem_we_o) begin
      check_eq("rstn_during_write", core_rstn_o, 0);
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_write", mem_we_o, 0);
      end else begin
        check_eq("write_addr", mem_addr_o, exp_addr_q.pop_front());
        check_eq("write_data", mem_wdata_o, exp_data_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    exp_addr_q.delete();
    exp_data_q.delete();
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  // Drive one byte from a negedge; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd) begin
      while ($urandom_range(1, 0) == 1) begin
        rx_valid_i = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("ready_timeout", rx_ready_o, 1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  // Frame from pay[]; nw payload words sent, chk_flip corrupts the checksum byte.
  task automatic send_frame(input bit with_magic, input logic [15:0] cnt, input int nw,
                            input bit rnd, input logic [7:0] chk_flip);
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    if (with_magic) send_byte(MAGIC, rnd);
    send_byte(cnt[7:0], rnd);
    send_byte(cnt[15:8], rnd);
    for (int i = 0; i < nw; i++) begin
      w = pay[i];
      exp_addr_q.push_back(ADDR_W'(i));
      exp_data_q.push_back(w);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], rnd);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(x ^ chk_flip, rnd);
`else
    if (chk_flip != 8'h00) $display("note: checksum byte not part of frame in this build");
`endif
  endtask

  task automatic finish_frame(input string tag, input bit ok);
    repeat (4) @(negedge clk);
    check_eq({tag, "_core_rstn"}, core_rstn_o, ok);
    check_eq({tag, "_err"}, err_o, !ok);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_ready"}, rx_ready_o, !ok);
    check_eq({tag, "_pending"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values while reset is held
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    #12;
    check_eq("rst_ready", rx_ready_o, 0);
    check_eq("rst_we", mem_we_o, 0);
    check_eq("rst_addr", mem_addr_o, 0);
    check_eq("rst_wdata", mem_wdata_o, 0);
    check_eq("rst_core_rstn", core_rstn_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_err", err_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", rx_ready_o, 1);

    // Frame A: two words, back to back
    pay[0] = 32'h12345678; pay[1] = 32'hDEADBEEF;
    send_frame(1'b1, 16'd2, 2, 1'b0, 8'h00);
    finish_frame("frameA", 1'b1);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: writes still happen, frame rejected, then a good frame recovers
    do_reset();
    send_frame(1'b1, 16'd2, 2, 1'b0, 8'h01);
    finish_frame("badchk", 1'b0);
    send_byte(MAGIC, 1'b0);
    check_eq("badchk_err_clear", err_o, 0);
    send_frame(1'b0, 16'd2, 2, 1'b0, 8'h00);
    finish_frame("badchk_recover", 1'b1);
`endif

    // Garbage before MAGIC is discarded
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h13, 1'b0);
    check_eq("garbage_busy", busy_o, 0);
    pay[0] = 32'h44332211;
    send_frame(1'b1, 16'd1, 1, 1'b0, 8'h00);
    finish_frame("garbage", 1'b1);

    // Oversize count, then restart from ERROR; payload contains MAGIC bytes
    do_reset();
    send_frame(1'b1, 16'h0401, 0, 1'b0, 8'h00);
    finish_frame("oversize", 1'b0);
    send_byte(MAGIC, 1'b0);
    check_eq("oversize_err_clear", err_o, 0);
    check_eq("oversize_restart_busy", busy_o, 1);
    pay[0] = 32'hA5A5A5A5;
    send_frame(1'b0, 16'd1, 1, 1'b0, 8'h00);
    finish_frame("restart", 1'b1);

    // Zero-length frame completes with no writes
    do_reset();
    send_frame(1'b1, 16'd0, 0, 1'b0, 8'h00);
    finish_frame("cnt0", 1'b1);

    // 16 words with random valid gaps
    do_reset();
    for (int i = 0; i < 16; i++) pay[i] = $urandom;
    send_frame(1'b1, 16'd16, 16, 1'b1, 8'h00);
    finish_frame("random16", 1'b1);

    // Async reset after 6 payload bytes
    do_reset();
    pay[0] = 32'h0BADF00D; pay[1] = 32'hCAFEBABE;
    send_byte(MAGIC, 1'b0); send_byte(8'd2, 1'b0); send_byte(8'd0, 1'b0);
    exp_addr_q.push_back(ADDR_W'(0));
    exp_data_q.push_back(pay[0]);
    for (int b = 0; b < 4; b++) send_byte(pay[0][8*b +: 8], 1'b0);
    send_byte(pay[1][7:0], 1'b0);
    send_byte(pay[1][15:8], 1'b0);
    check_eq("midrst_pre_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("midrst_ready", rx_ready_o, 0);
    check_eq("midrst_we", mem_we_o, 0);
    check_eq("midrst_addr", mem_addr_o, 0);
    check_eq("midrst_wdata", mem_wdata_o, 0);
    check_eq("midrst_core_rstn", core_rstn_o, 0);
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_err", err_o, 0);
    @(negedge clk);
    do_reset();
    pay[0] = 32'h01020304; pay[1] = 32'h05060708; pay[2] = 32'h090A0B0C;
    send_frame(1'b1, 16'd3, 3, 1'b0, 8'h00);
    finish_frame("after_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
